trace_fifo: RTL and testbench
=============================

TRACE_FIFO -- requirements
Module: trace_fifo

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 16, number of retire-record entries; power of two, 2..256.
REQ-003 Parameter CNT_W, default 16, width of the drop counter.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port in_valid  input  1  CPU retires one instruction this cycle.
REQ-007 Ports in_instruction 32, in_rd 5, in_rs1 5, in_rs2 5, in_rd_value 32, in_imm 12  input  retire record fields, 91 bits total.
REQ-008 Port out_valid  output  1  head record available to the trace logger.
REQ-009 Port out_ready  input  1  trace logger consumes the head record this cycle.
REQ-010 Ports out_instruction, out_rd, out_rs1, out_rs2, out_rd_value, out_imm  output  widths as REQ-007  head record.
REQ-011 Port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-012 Port full  output  1  count == DEPTH.
REQ-013 Port drop_cnt  output  CNT_W  records lost to overflow.

Function
REQ-014 Push SHALL occur when in_valid and (not full or pop); the record is written at the tail and the tail pointer increments modulo DEPTH.
REQ-015 Pop SHALL occur when out_valid and out_ready; the head pointer increments modulo DEPTH.
REQ-016 Output is first-word-fall-through: out_valid = (count != 0), and out_* reflect the head entry combinationally from storage.
REQ-017 A record pushed into an empty FIFO SHALL appear on out_* with out_valid=1 exactly one cycle after the push edge; no same-cycle bypass.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including when full (push accepted) and when count==1.
REQ-019 in_valid while full and without pop SHALL drop the incoming record; storage, pointers and count are unchanged.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 Records SHALL leave in push order; no field reordering or modification.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits and wrap silently; count SHALL never exceed DEPTH or underflow.

Reset
REQ-023 While rst=1 at a clock edge: head, tail and count = 0; out_valid=0; full=0; drop_cnt=0.
REQ-024 Storage contents SHALL NOT be reset; out_* data are don't-care while out_valid=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued records, overriding any push or pop in the same cycle; the first push after rst deasserts is accepted normally.

Configuration
REQ-026 Macro TRACE_FIFO_DROP_CNT_EN: when defined, drop_cnt increments by 1 on every dropped record (REQ-019), saturating at 2^CNT_W-1.
REQ-027 Without TRACE_FIFO_DROP_CNT_EN, drop_cnt SHALL be constant 0, no counter register is inferred, and dropping behaviour is otherwise identical.

Verification
REQ-028 Reset, then one push of instruction 0x00500093, rd=1, rd_value=5, out_ready=0 -> next cycle out_valid=1, out_instruction=0x00500093, count=1.
REQ-029 DEPTH=16: push 20 consecutive records with out_ready=0 -> full=1 after 16 pushes, count=16, records 1..16 retained, drop_cnt=4 (macro on) or 0 (macro off).
REQ-030 Full FIFO, in_valid=1 and out_ready=1 for 1 cycle -> count stays 16, drop_cnt unchanged, new record enters at tail.
REQ-031 Push and pop every cycle for 40 cycles with incrementing rd_value starting at 0 -> output rd_value sequence 0..39 in order, pointers wrap with no loss.
REQ-032 Fill to 5 entries, assert rst for 1 cycle while in_valid=1 and out_ready=1 -> count=0, out_valid=0, drop_cnt=0 next cycle.
REQ-033 Empty FIFO, out_ready=1 held for 3 cycles with in_valid=0 -> count stays 0, out_valid stays 0.

Source files
------------

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through queue of CPU retire records feeding a
// trace logger. Records arriving while the queue is full (and nothing leaves
// that cycle) are dropped.
// Optional feature macro: TRACE_FIFO_DROP_CNT_EN enables a saturating count
// of dropped records on drop_cnt; otherwise drop_cnt is tied to zero.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_instruction,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [31:0]              in_rd_value,
    input  logic [11:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_rd_value,
    output logic [11:0]              out_imm,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int DATA_W = 91;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;

    // A pop frees the head slot in the same cycle, so a full queue still
    // accepts a record when the logger is draining.
    assign out_valid = (occ != '0);
    assign full      = (occ == OCC_W'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);
    assign count     = occ;

    assign wr_data = {in_instruction, in_rd, in_rs1, in_rs2, in_rd_value, in_imm};
    assign rd_data = mem[head];

    assign out_instruction = rd_data[90:59];
    assign out_rd          = rd_data[58:54];
    assign out_rs1         = rd_data[53:49];
    assign out_rs2         = rd_data[48:44];
    assign out_rd_value    = rd_data[43:12];
    assign out_imm         = rd_data[11:0];

    // Record storage: written at the tail, never cleared by reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail] <= wr_data;
        end
    end

    // Head/tail pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef TRACE_FIFO_DROP_CNT_EN
    logic             drop;
    logic [CNT_W-1:0] drop_q;

    assign drop = in_valid & full & ~pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Saturating count of records lost to overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop) begin
            drop_q <= sat_inc(drop_q);
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_trace_fifo.sv
// Self-checking bench for trace_fifo: a directed vector table, hand-written
// corner-case sequences, and randomized traffic checked against a queue model.
module tb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [90:0] rec_t;

    typedef struct {
        bit          rst;
        bit          v;
        bit          rdy;
        rec_t        d;
        bit          exp_valid;
        int          exp_count;
        bit          exp_full;
        logic [31:0] exp_instr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_instruction;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [31:0]      in_rd_value;
    logic [11:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instruction;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [31:0]      out_rd_value;
    logic [11:0]      out_imm;
    logic [CW-1:0]    count;
    logic             full;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instruction(in_instruction), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_value(in_rd_value), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd_value(out_rd_value), .out_imm(out_imm),
        .count(count), .full(full), .drop_cnt(drop_cnt)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    rec_t mq[$];
    int   mdrop;
    logic [31:0] popped[$];

    function automatic rec_t mk(input logic [31:0] instr, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] val, input logic [11:0] imm);
        return {instr, rd, rs1, rs2, val, imm};
    endfunction

    function automatic rec_t rnd_rec();
        return mk($urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 12'($urandom));
    endfunction

    function automatic int exp_drop();
`ifdef TRACE_FIFO_DROP_CNT_EN
        return mdrop;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        rec_t head_rec;
        head_rec = {out_instruction, out_rd, out_rs1, out_rs2, out_rd_value, out_imm};
        chk("out_valid", 96'(out_valid), 96'(mq.size() != 0));
        chk("count", 96'(count), 96'(mq.size()));
        chk("full", 96'(full), 96'(mq.size() == DEPTH));
        chk("drop_cnt", 96'(drop_cnt), 96'(exp_drop()));
        if (mq.size() != 0) chk("head_record", 96'(head_rec), 96'(mq[0]));
    endtask

    // Apply one cycle of inputs, advance the model by the spec rules, then check.
    task automatic drive(input bit r, input bit v, input bit rdy, input rec_t d);
        bit pop, push;
        rst       = r;
        in_valid  = v;
        out_ready = rdy;
        {in_instruction, in_rd, in_rs1, in_rs2, in_rd_value, in_imm} = d;
        if (!r && rdy && out_valid) popped.push_back(out_rd_value);
        @(posedge clk);
        if (r) begin
            mq.delete();
            mdrop = 0;
        end else begin
            pop  = rdy && (mq.size() > 0);
            push = v && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
            else if (v && mdrop < (2**CNT_W - 1)) mdrop++;
        end
        #1;
        check_model();
    endtask

    vec_t tbl[$];

    initial begin
        rec_t r0;
        int   drop_before;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        {in_instruction, in_rd, in_rs1, in_rs2, in_rd_value, in_imm} = '0;
        mdrop = 0;

        // Directed table: reset, single push latency, idle pops, push/pop mixes.
        tbl.push_back('{1, 0, 0, '0, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 0, mk(32'h00500093, 5'd1, 5'd0, 5'd0, 32'd5, 12'd5), 1, 1, 0, 32'h00500093});
        tbl.push_back('{0, 0, 1, '0, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 0, 1, '0, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 0, 1, '0, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 0, 1, '0, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 1, mk(32'hAAAA0001, 5'd2, 5'd3, 5'd4, 32'd10, 12'h111), 1, 1, 0, 32'hAAAA0001});
        tbl.push_back('{0, 1, 0, mk(32'hAAAA0002, 5'd5, 5'd6, 5'd7, 32'd11, 12'h222), 1, 2, 0, 32'hAAAA0001});
        tbl.push_back('{0, 1, 1, mk(32'hAAAA0003, 5'd8, 5'd9, 5'd10, 32'd12, 12'h333), 1, 2, 0, 32'hAAAA0002});
        tbl.push_back('{0, 0, 1, '0, 1, 1, 0, 32'hAAAA0003});
        tbl.push_back('{0, 1, 1, mk(32'hAAAA0004, 5'd11, 5'd12, 5'd13, 32'd13, 12'h444), 1, 1, 0, 32'hAAAA0004});
        tbl.push_back('{0, 0, 1, '0, 0, 0, 0, 32'h0});
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].rdy, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), 96'(out_valid), 96'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_count", i), 96'(count), 96'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_full", i), 96'(full), 96'(tbl[i].exp_full));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_instr", i), 96'(out_instruction), 96'(tbl[i].exp_instr));
        end

        // Overflow: 20 pushes into 16 slots, records 1..16 kept.
        drive(1, 0, 0, '0);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 0, mk(32'h1000 + i, 5'(i), 5'd0, 5'd0, 32'(i), 12'(i)));
            if (i == 16) chk("full_after_16", 96'(full), 96'd1);
        end
        chk("ovf_count", 96'(count), 96'd16);
        chk("ovf_head", 96'(out_rd_value), 96'd1);
`ifdef TRACE_FIFO_DROP_CNT_EN
        chk("ovf_drop", 96'(drop_cnt), 96'd4);
`else
        chk("ovf_drop", 96'(drop_cnt), 96'd0);
`endif
        // Full with push and pop together: push accepted, no drop.
        drop_before = int'(drop_cnt);
        drive(0, 1, 1, mk(32'h2000, 5'd31, 5'd1, 5'd2, 32'd100, 12'hABC));
        chk("fullpp_count", 96'(count), 96'd16);
        chk("fullpp_drop", 96'(drop_cnt), 96'(drop_before));
        chk("fullpp_head", 96'(out_rd_value), 96'd2);
        for (int i = 0; i < 16; i++) drive(0, 0, 1, '0);
        chk("drained", 96'(out_valid), 96'd0);

        // Streaming: push and pop every cycle, pointers wrap without loss.
        drive(1, 0, 0, '0);
        popped.delete();
        for (int i = 0; i < 40; i++) drive(0, 1, 1, mk(32'h3000, 5'd1, 5'd2, 5'd3, 32'(i), 12'd0));
        drive(0, 0, 1, '0);
        chk("stream_len", 96'(popped.size()), 96'd40);
        for (int i = 0; i < popped.size() && i < 40; i++)
            chk($sformatf("stream_%0d", i), 96'(popped[i]), 96'(i));

        // Reset mid-operation overrides a simultaneous push and pop.
        for (int i = 0; i < 5; i++) drive(0, 1, 0, rnd_rec());
        chk("pre_rst_count", 96'(count), 96'd5);
        drive(1, 1, 1, rnd_rec());
        chk("rst_count", 96'(count), 96'd0);
        chk("rst_valid", 96'(out_valid), 96'd0);
        chk("rst_drop", 96'(drop_cnt), 96'd0);
        r0 = rnd_rec();
        drive(0, 1, 0, r0);
        chk("post_rst_push", 96'(count), 96'd1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 35)), rnd_rec());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
